// File: rtl/seg_scan_reader_pkg.sv
// seg_scan_reader_pkg: glyph table, scan FSM states and decoded-digit record
package seg_scan_reader_pkg;
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;
  localparam logic [15:0][6:0] GLYPHS = {GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
                                         GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0};
  typedef enum logic [1:0] {IDLE, SETTLING, SAMPLED} scan_state_e;
  typedef struct packed {
    logic       err;
    logic [3:0] nibble;
  } seg_val_t;
endpackage

// File: rtl/seg_glyph_match.sv
// seg_glyph_match: active-low 7-segment pattern to {err, nibble}; unknown patterns give err=1, nibble=0
module seg_glyph_match
  import seg_scan_reader_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output seg_val_t   val_o
);
  always_comb begin
    val_o = '{err: 1'b1, nibble: 4'd0};
    for (int i = 0; i < 16; i++)
      if (seg_n_i == GLYPHS[i]) val_o = '{err: 1'b0, nibble: 4'(i)};
  end
endmodule

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: samples a multiplexed active-low 7-segment bus, debounces each digit
// over several scans and streams accepted digit changes over valid/ready.
module seg_scan_reader
  import seg_scan_reader_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SETTLE       = 4,
  parameter int STABLE_SCANS = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_digit,
  output logic [3:0]              out_nibble,
  output logic                    out_err,
  output logic [4*NUM_DIGITS-1:0] disp_value,
  output logic [NUM_DIGITS-1:0]   disp_err
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [3:0] FULL = 4'(STABLE_SCANS);
  scan_state_e                 state_q;
  logic [SW-1:0]               settle_q;
  logic [NUM_DIGITS-1:0]       dig_q, seen_q, seen_d, pend_q, pend_d, acc, clr, avail;
  seg_val_t [NUM_DIGITS-1:0]   cand_q, cand_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0][3:0]  agree_q, agree_d;
  logic [IW-1:0]               smp_idx, nxt, digit_q, digit_d;
  logic                        valid_q, valid_d, dig_chg, smp_fire;
  seg_val_t                    smp;
  seg_glyph_match u_match (.seg_n_i(seg_n), .val_o(smp));
  assign dig_chg  = dig_n != dig_q;
  assign smp_fire = state_q == SETTLING && !dig_chg && settle_q == SW'(SETTLE - 1);
  always_comb begin
    smp_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) if (!dig_n[i]) smp_idx = IW'(i);
    cand_d  = cand_q;
    agree_d = agree_q;
    disp_d  = disp_q;
    seen_d  = seen_q;
    acc     = '0;
    if (smp_fire) begin
      cand_d[smp_idx]  = smp;
      agree_d[smp_idx] = cand_q[smp_idx] != smp ? 4'd1 :
                         agree_q[smp_idx] == FULL ? FULL : agree_q[smp_idx] + 4'd1;
      // seen_q forces the first acceptance even when the value equals the reset contents
      if (agree_d[smp_idx] == FULL && (!seen_q[smp_idx] || disp_q[smp_idx] != smp)) begin
        acc[smp_idx]    = 1'b1;
        disp_d[smp_idx] = smp;
        seen_d[smp_idx] = 1'b1;
      end
    end
    clr = '0;
    if (valid_q && out_ready) clr[digit_q] = 1'b1;
    avail  = pend_q & ~clr;
    pend_d = avail | acc;
    nxt    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) if (avail[i]) nxt = IW'(i);
    valid_d = valid_q;
    digit_d = digit_q;
    if (!valid_q || out_ready) begin
      valid_d = |avail;
      digit_d = |avail ? nxt : digit_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      dig_q    <= '1;
      cand_q   <= '0;
      agree_q  <= '0;
      disp_q   <= '0;
      seen_q   <= '0;
      pend_q   <= '0;
      valid_q  <= 1'b0;
      digit_q  <= '0;
    end else begin
      dig_q <= dig_n;
      if (dig_chg) state_q <= IDLE;
      else
        case (state_q)
          IDLE: if ($onehot(~dig_n)) begin
            state_q  <= SETTLING;
            settle_q <= '0;
          end
          SETTLING: begin
            settle_q <= settle_q + SW'(1);
            if (smp_fire) state_q <= SAMPLED;
          end
          default: ;
        endcase
      cand_q  <= cand_d;
      agree_q <= agree_d;
      disp_q  <= disp_d;
      seen_q  <= seen_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      digit_q <= digit_d;
    end
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_disp
    assign disp_value[4*i +: 4] = disp_q[i].nibble;
    assign disp_err[i]          = disp_q[i].err;
  end
  assign out_valid  = valid_q;
  assign out_digit  = 3'(digit_q);
  assign out_nibble = disp_q[digit_q].nibble;
  assign out_err    = disp_q[digit_q].err;
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: directed scans of the seven-segment bus with hand-computed events and display values
module tb_seg_scan_reader;
  import seg_scan_reader_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        out_valid, out_ready, out_err;
  logic [2:0]  out_digit;
  logic [3:0]  out_nibble;
  logic [15:0] disp_value;
  logic [3:0]  disp_err;
  int          vectors = 0;
  int          errs = 0;
  logic [7:0]  ev_q[$];
  seg_scan_reader #(.NUM_DIGITS(4), .SETTLE(4), .STABLE_SCANS(3)) dut (
    .clk(clk), .reset_n(reset_n), .seg_n(seg_n), .dig_n(dig_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_nibble(out_nibble), .out_err(out_err), .disp_value(disp_value), .disp_err(disp_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (reset_n && out_valid && out_ready) ev_q.push_back({out_digit, out_err, out_nibble});
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] ev(input int i);
    return ev_q.size() > i ? ev_q[i] : 8'hFF;
  endfunction
  task automatic strobe(input int d, input logic [6:0] pat, input int n);
    dig_n = ~(4'(1) << d);
    seg_n = pat;
    repeat (n) @(negedge clk);
  endtask
  task automatic blank();
    dig_n = '1;
    seg_n = '1;
    @(negedge clk);
  endtask
  task automatic scan(input int d, input logic [6:0] pat, input int reps, input int len);
    repeat (reps) begin
      strobe(d, pat, len);
      blank();
    end
  endtask
  logic [6:0] pats [4];
  initial begin
    reset_n = 1'b0; out_ready = 1'b1; dig_n = '1; seg_n = '1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_digit", out_digit, 0);
    chk("rst_nibble", out_nibble, 0);
    chk("rst_err", out_err, 0);
    chk("rst_disp_value", disp_value, 0);
    chk("rst_disp_err", disp_err, 0);
    // digit0 shows 3; third sample accepts, disp then out_valid follow one cycle apart
    scan(0, GLYPH_3, 2, 8);
    strobe(0, GLYPH_3, 5);
    chk("t1_disp_before", disp_value, 0);
    strobe(0, GLYPH_3, 1);
    chk("t1_disp_after", disp_value[3:0], 3);
    chk("t1_valid_not_yet", out_valid, 0);
    strobe(0, GLYPH_3, 1);
    chk("t1_valid_rise", out_valid, 1);
    chk("t1_out_nibble", out_nibble, 3);
    strobe(0, GLYPH_3, 1);
    chk("t1_valid_drop", out_valid, 0);
    blank();
    chk("t1_events", ev_q.size(), 1);
    chk("t1_ev0", ev(0), 8'h03);
    // four digits steady for ten scans
    ev_q.delete();
    pats = '{GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4};
    for (int s = 0; s < 10; s++)
      for (int d = 0; d < 4; d++) begin
        strobe(d, pats[d], 8);
        blank();
      end
    chk("t2_events", ev_q.size(), 4);
    chk("t2_ev0", ev(0), 8'h01);
    chk("t2_ev1", ev(1), 8'h22);
    chk("t2_ev2", ev(2), 8'h43);
    chk("t2_ev3", ev(3), 8'h64);
    chk("t2_disp", disp_value, 16'h4321);
    // digit2 flickers between 5 and 6
    ev_q.delete();
    for (int s = 0; s < 4; s++) begin
      scan(2, GLYPH_5, 1, 8);
      scan(2, GLYPH_6, 1, 8);
    end
    repeat (3) @(negedge clk);
    chk("t3_events", ev_q.size(), 0);
    chk("t3_disp", disp_value, 16'h4321);
    // digit1 shows a non-glyph pattern
    ev_q.delete();
    scan(1, 7'h7F, 3, 8);
    repeat (3) @(negedge clk);
    chk("t4_events", ev_q.size(), 1);
    chk("t4_ev0", ev(0), 8'h30);
    chk("t4_disp_err", disp_err, 4'b0010);
    chk("t4_disp", disp_value, 16'h4301);
    // back-pressure while digit0 goes 7 then 8: one coalesced event
    ev_q.delete();
    out_ready = 1'b0;
    scan(0, GLYPH_7, 3, 8);
    chk("t5_valid_7", out_valid, 1);
    chk("t5_digit_7", out_digit, 0);
    chk("t5_nibble_7", out_nibble, 7);
    scan(0, GLYPH_8, 3, 8);
    chk("t5_valid_8", out_valid, 1);
    chk("t5_digit_8", out_digit, 0);
    chk("t5_nibble_8", out_nibble, 8);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_events", ev_q.size(), 1);
    chk("t5_ev0", ev(0), 8'h08);
    chk("t5_valid_off", out_valid, 0);
    // strobes too short to settle, and two strobes at once
    ev_q.delete();
    scan(3, GLYPH_0, 5, 4);
    for (int s = 0; s < 3; s++) begin
      dig_n = 4'b1100;
      seg_n = GLYPH_0;
      repeat (8) @(negedge clk);
      blank();
    end
    repeat (3) @(negedge clk);
    chk("t6_events", ev_q.size(), 0);
    chk("t6_disp", disp_value, 16'h4308);
    chk("t6_disp_err", disp_err, 4'b0010);
    // reset while settling with digit0 pending
    ev_q.delete();
    out_ready = 1'b0;
    scan(0, GLYPH_5, 3, 8);
    chk("t7_pending", out_valid, 1);
    strobe(2, GLYPH_1, 3);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_disp", disp_value, 0);
    chk("t7_rst_err", disp_err, 0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    dig_n = '1;
    repeat (10) @(negedge clk);
    chk("t7_no_event", ev_q.size(), 0);
    chk("t7_valid_idle", out_valid, 0);
    // first acceptance after reset is reported even though it matches the reset value
    scan(0, GLYPH_0, 3, 8);
    repeat (4) @(negedge clk);
    chk("t8_events", ev_q.size(), 1);
    chk("t8_ev0", ev(0), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/seg_scan_reader.md
# seg_scan_reader

Receive-side counterpart of the hex-to-seven-segment decoders. It watches a multiplexed, active-low seven-segment bus (segment lines plus a digit strobe) and recovers the hex nibble each digit shows. Stable digit changes are reported over a valid/ready stream and held in a parallel register. It sits in the display self-check and loopback path, monitoring what the display drivers actually emit.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (1–8).
- SETTLE, 4: cycles a strobe must stay unchanged before the segments are sampled (≥1).
- STABLE_SCANS, 3: consecutive identical samples of a digit required before a change is accepted (1–15).
- clk  in  1: single clock, all logic on rising edge.
- reset_n  in  1: synchronous, active-low reset.
- seg_n  in  7: segment lines, active-low, bit order {g,f,e,d,c,b,a}.
- dig_n  in  NUM_DIGITS: digit strobes, active-low, nominally one-hot.
- out_valid  out  1: an event is presented.
- out_ready  in  1: the consumer accepts the event.
- out_digit  out  3: digit index of the event.
- out_nibble  out  4: decoded value (0 when out_err=1).
- out_err  out  1: the accepted pattern is not one of the 16 glyphs.
- disp_value  out  4·NUM_DIGITS: last accepted nibble per digit; digit i is at [4i+3:4i].
- disp_err  out  NUM_DIGITS: last accepted error flag per digit.

## Operation
- Glyph set (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Any other pattern decodes to err=1, nibble=0.
- Scan FSM has three states: IDLE, SETTLING, SAMPLED.
  - IDLE → SETTLING when exactly one dig_n bit is low. Settle counter cleared.
  - SETTLING counts while dig_n is unchanged. When the count reaches SETTLE, the block samples seg_n, decodes it, and moves to SAMPLED.
  - SAMPLED holds until dig_n changes. Only one sample is taken per strobe assertion.
  - In any state, a change in dig_n returns the FSM to IDLE and re-evaluates next cycle. All-high or multi-low strobes stay in IDLE and are never sampled.
- Per-digit agreement tracking:
  - Each digit keeps a candidate {err, nibble} and a 4-bit agree count.
  - A sample equal to the candidate increments the count, saturating at STABLE_SCANS.
  - A sample that differs replaces the candidate and sets the count to 1.
- Acceptance:
  - A digit is accepted on the cycle its count reaches STABLE_SCANS and the candidate differs from disp_value/disp_err for that digit. The first acceptance after reset always counts as different.
  - On acceptance, disp_value/disp_err update immediately and the digit's pending bit is set.
- Event output:
  - Pending digits are emitted lowest index first. Output fields always come from the current disp_* of out_digit.
  - A digit that changes again while pending stays pending once (coalesced). The emitted data is the latest accepted value.
- Handshake:
  - out_valid, once raised, stays high and out_digit stays fixed until out_valid & out_ready.
  - out_nibble/out_err may change while pending only because of coalescing.
  - On the accept cycle, the pending bit clears. If the same digit is accepted on that same cycle, its pending bit stays set.

## Timing
- Reset values: out_valid=0, out_digit=0, out_nibble=0, out_err=0, disp_value=0, disp_err=0. All candidates, counts, pending bits, and the FSM (IDLE) are cleared.
- Reset asserted mid-operation discards every pending event and any settle in progress.
- Sample latency: a strobe that becomes stable at cycle t is sampled at cycle t+SETTLE+1, which is 1 cycle for the IDLE→SETTLING step plus SETTLE cycles of counting.
- disp_* update in the cycle after the accepting sample. out_valid rises in the cycle after that if no event is already being presented.
- Back-to-back events: out_valid can stay high across consecutive accepts, one event per cycle.
- Throughput limit: a strobe held for fewer than SETTLE+1 cycles is never sampled. This is intended.

## Structure
- Shared package holds:
  - the glyph constants (GLYPH_0 … GLYPH_F);
  - the scan FSM state enum;
  - the {err, nibble} record type, also used by the decoder-side testbenches.
- One sub-module, seg_glyph_match: combinational 7-bit pattern → {err, nibble}, reusable by other monitors.
- The FSM, per-digit trackers, pending arbiter, and output register live in the top.

## Test plan
- Reset, then scan digit0=GLYPH_3 with STABLE_SCANS=3 (3 strobes of 8 cycles each) → one event {digit 0, nibble 3, err 0}; disp_value[3:0]=3.
- Hold all four digits steady with 1,2,3,4 for 10 scans, out_ready=1 → exactly four events, in order digits 0,1,2,3; no repeats.
- Digit2 alternates GLYPH_5 / GLYPH_6 every scan → no event; disp_value unchanged.
- Digit1 shows pattern 1111111 for 3 scans → event {digit 1, err 1, nibble 0}; disp_err[1]=1.
- out_ready=0 while digit0 goes 7→8 → out_valid stays high, digit index fixed, nibble reads 8 at release; one event only.
- Strobe held for SETTLE cycles only, or two strobes low at once → no sample. Reset asserted during SETTLING with digit0 pending → out_valid=0 and disp_value=0 next cycle.
